// File: rtl/proc_io_test_sequencer.sv
// Self-checking sequencer for the accumulator processor's I/O port.
// For each vector it holds the processor in reset, then presents the input on
// dut_in. It releases reset and waits until dut_out has matched the expected
// value for STABLE_CYCLES consecutive cycles, or until TIMEOUT cycles pass.
// The pass/fail result for each vector is accumulated in the counts and mask.
module proc_io_test_sequencer #(
  parameter int WIDTH         = 16,
  parameter int NUM_VEC       = 4,
  parameter int RESET_CYCLES  = 4,
  parameter int TIMEOUT       = 1024,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_VEC*WIDTH-1:0]   vec_in,
  input  logic [NUM_VEC*WIDTH-1:0]   vec_exp,
  input  logic [WIDTH-1:0]           dut_out,
  output logic                       dut_reset,
  output logic [WIDTH-1:0]           dut_in,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_VEC):0]   cur_vec,
  output logic [$clog2(NUM_VEC):0]   pass_count,
  output logic [$clog2(NUM_VEC):0]   fail_count,
  output logic [NUM_VEC-1:0]         fail_mask
);

  // Width of the result counts and of the cur_vec port.
  localparam int CW    = $clog2(NUM_VEC) + 1;
  // Internal vector index: exactly wide enough to address the lookup tables.
  localparam int IW    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int DEPTH = 1 << IW;
  // Counter widths, each sized to hold its terminal count.
  localparam int HW    = $clog2(RESET_CYCLES + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int SW    = $clog2(STABLE_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   cycle_cnt;
  logic [SW-1:0]   stable_cnt;

  // Unflattened views of the vector buses. Entries past NUM_VEC are
  // padding so that every idx value addresses a defined entry.
  logic [WIDTH-1:0] in_tab  [DEPTH];
  logic [WIDTH-1:0] exp_tab [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    if (k < NUM_VEC) begin : g_live
      assign in_tab[k]  = vec_in[k*WIDTH +: WIDTH];
      assign exp_tab[k] = vec_exp[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign in_tab[k]  = '0;
      assign exp_tab[k] = '0;
    end
  end

  // Next-state helpers for the RUN decision. The stable run restarts on any
  // mismatch, so only an unbroken streak can reach STABLE_MAX.
  logic              match;
  logic [SW-1:0]     stable_nxt;
  logic [TW-1:0]     cycle_nxt;
  logic [IW-1:0]     idx_nxt;
  logic              last_vec;
  logic [NUM_VEC-1:0] vec_bit;

  assign match      = (dut_out == exp_tab[idx]);
  assign stable_nxt = match ? stable_cnt + SW'(1) : '0;
  assign cycle_nxt  = cycle_cnt + TW'(1);
  assign idx_nxt    = idx + IW'(1);
  assign last_vec   = (idx == LAST_IDX);
  assign vec_bit    = NUM_VEC'(1) << idx;

  assign cur_vec    = CW'(idx);

  // Sequencer FSM. Every output is registered, so no combinational path runs
  // from dut_out back to dut_reset or dut_in.
  // NOTE: all state here updates with <= so that every branch reads the
  // pre-edge values, whatever order the statements are written in.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      hold_cnt   <= '0;
      cycle_cnt  <= '0;
      stable_cnt <= '0;
      dut_reset  <= 1'b1;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      fail_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_HOLD;
            idx        <= '0;
            hold_cnt   <= '0;
            pass_count <= '0;
            fail_count <= '0;
            fail_mask  <= '0;
            dut_in     <= in_tab[0];
            dut_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= ST_RUN;
            dut_reset  <= 1'b0;
            cycle_cnt  <= '0;
            stable_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        ST_RUN: begin
          cycle_cnt  <= cycle_nxt;
          stable_cnt <= stable_nxt;
          // The pass test comes first, so a pass in the timeout cycle still counts.
          if (stable_nxt == STABLE_MAX) begin
            pass_count <= pass_count + CW'(1);
            dut_reset  <= 1'b1;
            state      <= ST_NEXT;
          end else if (cycle_nxt == TIMEOUT_MAX) begin
            fail_count <= fail_count + CW'(1);
            fail_mask  <= fail_mask | vec_bit;
            dut_reset  <= 1'b1;
            state      <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx      <= idx_nxt;
            dut_in   <= in_tab[idx_nxt];
            hold_cnt <= '0;
            state    <= ST_HOLD;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_io_test_sequencer.sv
// Directed bench for proc_io_test_sequencer. It uses two instances: a
// single-vector one and a four-vector one. Each is driven by a small
// behavioural model of the processor that produces the sum 1..n of its input
// a fixed number of cycles after reset is released.
module tb_proc_io_test_sequencer;

  logic clk;
  logic rst;

  // Single-vector instance (default TIMEOUT 1024, STABLE 8, RESET 4).
  logic        start1;
  logic [15:0] vin1, vexp1, out1, dut_in1;
  logic        dut_reset1, busy1, done1;
  logic [0:0]  cur1, pass1, fail1, mask1;
  logic        mode1;   // 0: settling sum model, 1: glitching output
  int          run1;

  // Four-vector instance with a short timeout.
  logic        start4;
  logic [63:0] vin4, vexp4;
  logic [15:0] out4, dut_in4;
  logic        dut_reset4, busy4, done4;
  logic [2:0]  cur4, pass4, fail4;
  logic [3:0]  mask4;
  int          run4;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  proc_io_test_sequencer #(
    .WIDTH(16), .NUM_VEC(1), .RESET_CYCLES(4), .TIMEOUT(1024), .STABLE_CYCLES(8)
  ) u_one (
    .CLK(clk), .reset(rst), .start(start1), .vec_in(vin1), .vec_exp(vexp1),
    .dut_out(out1), .dut_reset(dut_reset1), .dut_in(dut_in1), .busy(busy1),
    .done(done1), .cur_vec(cur1), .pass_count(pass1), .fail_count(fail1),
    .fail_mask(mask1)
  );

  proc_io_test_sequencer #(
    .WIDTH(16), .NUM_VEC(4), .RESET_CYCLES(4), .TIMEOUT(64), .STABLE_CYCLES(8)
  ) u_four (
    .CLK(clk), .reset(rst), .start(start4), .vec_in(vin4), .vec_exp(vexp4),
    .dut_out(out4), .dut_reset(dut_reset4), .dut_in(dut_in4), .busy(busy4),
    .done(done4), .cur_vec(cur4), .pass_count(pass4), .fail_count(fail4),
    .fail_mask(mask4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sum_to(input logic [15:0] n);
    return 16'((int'(n) * (int'(n) + 1)) / 2);
  endfunction

  // Processor run-time counters: they are held at 0 while in reset and count up once released.
  always @(posedge clk) begin
    if (dut_reset1) run1 <= 0;
    else            run1 <= run1 + 1;
    if (dut_reset4) run4 <= 0;
    else            run4 <= run4 + 1;
  end

  // Processor output models.
  always_comb begin
    out1 = 16'h0;
    if (!mode1) begin
      if (run1 >= 300) out1 = sum_to(dut_in1);
    end else begin
      out1 = (run1 == 5) ? 16'd54 : 16'd55;
    end
    out4 = (run4 >= 10) ? sum_to(dut_in4) : 16'h0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic pulse_start4();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    int falls;
    logic prev;

    rst    = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    mode1  = 1'b0;
    vin1   = 16'd10;
    vexp1  = 16'd55;
    vin4   = {16'd10, 16'd3, 16'd2, 16'd1};
    vexp4  = {16'd55, 16'd7, 16'd3, 16'd1};   // vector 2 expectation corrupted

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dut_reset", dut_reset1, 1);
    check("rst_dut_in",    dut_in1,    0);
    check("rst_busy",      busy1,      0);
    check("rst_done",      done1,      0);
    check("rst_cur_vec",   cur4,       0);
    check("rst_counts",    {pass4, fail4, mask4}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_dut_reset", dut_reset1, 1);
    check("idle_busy",      busy1,      0);

    // Sum program passes after the model settles at 300 cycles.
    pulse_start1();
    check("s1_busy",   busy1,   1);
    check("s1_dut_in", dut_in1, 10);
    repeat (3) @(negedge clk);
    check("s1_hold_last", dut_reset1, 1);
    @(negedge clk);
    check("s1_run_entry", dut_reset1, 0);
    repeat (307) @(negedge clk);
    check("s1_not_yet", pass1, 0);
    @(negedge clk);
    check("s1_pass",      pass1, 1);
    check("s1_next_busy", busy1, 1);
    check("s1_next_rst",  dut_reset1, 1);
    @(negedge clk);
    check("s1_done",   done1, 1);
    check("s1_idle",   busy1, 0);
    check("s1_fail",   fail1, 0);
    check("s1_mask",   mask1, 0);

    // Wrong expectation: the vector fails exactly TIMEOUT cycles into RUN.
    vexp1 = 16'd56;
    pulse_start1();
    check("s2_cleared", pass1, 0);
    check("s2_done_lo", done1, 0);
    repeat (4) @(negedge clk);
    check("s2_run_entry", dut_reset1, 0);
    repeat (1023) @(negedge clk);
    check("s2_not_yet", fail1, 0);
    @(negedge clk);
    check("s2_fail", fail1, 1);
    check("s2_mask", mask1, 1);
    check("s2_pass", pass1, 0);
    @(negedge clk);
    check("s2_done", done1, 1);

    // One-cycle glitch restarts the stable count.
    mode1 = 1'b1;
    vexp1 = 16'd55;
    pulse_start1();
    repeat (4) @(negedge clk);
    check("s3_run_entry", dut_reset1, 0);
    repeat (13) @(negedge clk);
    check("s3_not_yet", pass1, 0);
    @(negedge clk);
    check("s3_pass", pass1, 1);
    @(negedge clk);
    check("s3_done", done1, 1);

    // Four vectors, vector 2 fails.
    pulse_start4();
    check("s4_cur0",  cur4,    0);
    check("s4_in0",   dut_in4, 1);
    rises = 0;
    falls = 0;
    prev  = dut_reset4;
    for (int i = 0; i < 400 && !done4; i++) begin
      @(negedge clk);
      if (!prev && dut_reset4) rises++;
      if (prev && !dut_reset4) falls++;
      prev = dut_reset4;
    end
    check("s4_done",   done4, 1);
    check("s4_rises",  rises, 4);
    check("s4_falls",  falls, 4);
    check("s4_pass",   pass4, 3);
    check("s4_fail",   fail4, 1);
    check("s4_mask",   mask4, 4'b0100);
    check("s4_cur",    cur4,  3);
    check("s4_dut_in", dut_in4, 10);

    // Start from DONE clears results and restarts at vector 0.
    pulse_start4();
    check("s6_restart_counts", {pass4, fail4, mask4}, 0);
    check("s6_restart_cur",    cur4,  0);
    check("s6_restart_busy",   busy4, 1);
    check("s6_restart_done",   done4, 0);

    // Reset during RUN of vector 1 aborts immediately.
    for (int i = 0; i < 200 && !(cur4 == 3'd1 && !dut_reset4); i++) @(negedge clk);
    check("s5_in_run1", {cur4, dut_reset4}, {3'd1, 1'b0});
    check("s5_pre_pass", pass4, 1);
    #2 rst = 1'b1;
    #1;
    check("s5_dut_reset", dut_reset4, 1);
    check("s5_busy",      busy4,      0);
    check("s5_done",      done4,      0);
    check("s5_cur",       cur4,       0);
    check("s5_counts",    {pass4, fail4, mask4}, 0);
    check("s5_dut_in",    dut_in4,    0);
    @(negedge clk);
    rst = 1'b0;

    // Rerun from vector 0.
    pulse_start4();
    check("s5_rerun_cur", cur4,    0);
    check("s5_rerun_in",  dut_in4, 1);

    // Start while busy is ignored.
    for (int i = 0; i < 200 && !(cur4 == 3'd2 && !dut_reset4); i++) @(negedge clk);
    check("s6_in_run2", {cur4, dut_reset4}, {3'd2, 1'b0});
    pulse_start4();
    check("s6_busy_cur",  cur4,  2);
    check("s6_busy_pass", pass4, 2);
    check("s6_busy_busy", busy4, 1);
    for (int i = 0; i < 400 && !done4; i++) @(negedge clk);
    check("s6_done", done4, 1);
    check("s6_pass", pass4, 3);
    check("s6_fail", fail4, 1);
    check("s6_mask", mask4, 4'b0100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
